mmio_router: RTL and testbench

Parametrised data-side address router between the CPU memory stage and its memory system. Each access is steered either to the data cache (the default region) or to one of `NUM_REGIONS` memory-mapped peripheral slots, such as text memory, timer, keyboard or loader RAM. Peripheral accesses run through a per-slot fixed-latency handshake: the router registers the request, issues a one-cycle strobe, waits the slot's configured latency and captures read data. It holds `mem_stall` high until the access completes.

---
 rtl/mmio_router_pkg.sv | 26 ++
 rtl/mmio_decode.sv | 32 +++
 rtl/mmio_router.sv | 196 +++++++++++++++++++
 tb/tb_mmio_router.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_router_pkg.sv
// Shared definitions for the data-side MMIO router.
//   - state_e         : 2-bit FSM encoding (IDLE, STROBE, WAIT, DONE)
//   - WAIT_W          : width of each per-slot wait field
//   - DEF_REGION_ID   : default region IDs for the vmem/timer/keyboard/loader map
//   - DEF_REGION_WAIT : default wait cycles for the same map
//   - slot_w()        : width of a slot index, at least one bit
package mmio_router_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStrobe = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam int unsigned WAIT_W = 4;

    // Slot 0 = text memory, 1 = timer, 2 = keyboard, 3 = loader RAM.
    localparam logic [15:0] DEF_REGION_ID   = {4'hf, 4'he, 4'hd, 4'hc};
    localparam logic [15:0] DEF_REGION_WAIT = {4'd1, 4'd0, 4'd0, 4'd2};

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decoder.
// Compares the address region field against every slot ID; the lowest-index
// matching slot wins.
//   sel  in  SEL_W  : address region field
//   hit  out 1      : some slot matched
//   slot out SLOT_W : index of the winning slot (0 when no hit)
module mmio_decode
    import mmio_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned SLOT_W      = 2,
    parameter logic [NUM_REGIONS*SEL_W-1:0] REGION_ID = DEF_REGION_ID
) (
    input  logic [SEL_W-1:0]  sel,
    output logic              hit,
    output logic [SLOT_W-1:0] slot
);

    // Walk from the top down so the lowest index is the last write and wins.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (sel == REGION_ID[i*SEL_W +: SEL_W]) begin
                hit  = 1'b1;
                slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Data-side address router between the CPU memory stage and the memory system.
// Accesses are steered to the data cache (default region) or to one of
// NUM_REGIONS peripheral slots. A peripheral access is registered, issues a
// one-cycle strobe, waits the slot's fixed latency, captures read data and
// then releases mem_stall for exactly one cycle (DONE).
//   clk, rst          : clock, asynchronous active-low reset
//   dmem_read_in/write_in, dmem_addr, data_from_reg, dmem_byte_w_en : CPU request
//   dmem_data_out, mem_stall : CPU response
//   dc_read_out, dc_write_out, dc_data_in, cache_stall : data cache side
//   per_sel, per_stb, per_wen, per_addr, per_wdata, per_be, per_rdata : peripheral side
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SEL_MSB     = 29,
    parameter int unsigned SEL_LSB     = 26,
    parameter logic [NUM_REGIONS*(SEL_MSB-SEL_LSB+1)-1:0] REGION_ID   = DEF_REGION_ID,
    parameter logic [NUM_REGIONS*WAIT_W-1:0]              REGION_WAIT = DEF_REGION_WAIT
) (
    input  logic                          clk,
    input  logic                          rst,
    // CPU side
    input  logic                          dmem_read_in,
    input  logic                          dmem_write_in,
    input  logic [ADDR_W-1:0]             dmem_addr,
    input  logic [DATA_W-1:0]             data_from_reg,
    input  logic [DATA_W/8-1:0]           dmem_byte_w_en,
    output logic [DATA_W-1:0]             dmem_data_out,
    output logic                          mem_stall,
    // Data cache side
    output logic                          dc_read_out,
    output logic                          dc_write_out,
    input  logic [DATA_W-1:0]             dc_data_in,
    input  logic                          cache_stall,
    // Peripheral side
    output logic [NUM_REGIONS-1:0]        per_sel,
    output logic                          per_stb,
    output logic                          per_wen,
    output logic [ADDR_W-1:0]             per_addr,
    output logic [DATA_W-1:0]             per_wdata,
    output logic [DATA_W/8-1:0]           per_be,
    input  logic [NUM_REGIONS*DATA_W-1:0] per_rdata
);

    localparam int unsigned SEL_W  = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned SLOT_W = slot_w(NUM_REGIONS);
    localparam int unsigned BE_W   = DATA_W / 8;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                hit;
    logic [SLOT_W-1:0]   hit_slot;
    logic                req;
    logic                per_start;
    logic [WAIT_W-1:0]   wait_sel;
    logic [DATA_W-1:0]   rdata_sel;

    mmio_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .SEL_W       (SEL_W),
        .SLOT_W      (SLOT_W),
        .REGION_ID   (REGION_ID)
    ) u_decode (
        .sel  (dmem_addr[SEL_MSB:SEL_LSB]),
        .hit  (hit),
        .slot (hit_slot)
    );

    assign req       = dmem_read_in | dmem_write_in;
    assign per_start = req & hit;

    // Per-slot latency and read data, selected by the registered slot so that
    // CPU input changes mid-access have no effect.
    always_comb begin
        wait_sel  = '0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                wait_sel  = REGION_WAIT[i*WAIT_W +: WAIT_W];
                rdata_sel = per_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (per_start) begin
                    slot_d  = hit_slot;
                    // Read and write together is treated as a write.
                    wen_d   = dmem_write_in;
                    addr_d  = dmem_addr;
                    wdata_d = data_from_reg;
                    be_d    = dmem_byte_w_en;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                cnt_d   = wait_sel;
                state_d = (wait_sel != '0) ? StWait : StDone;
            end
            StWait: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Always pass through IDLE so a held request starts a fresh access.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Read data is sampled on the edge that enters DONE.
        if (state_d == StDone && state_q != StDone && !wen_q) begin
            rdata_d = rdata_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            slot_q  <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Peripheral outputs are derived from state and registered copies only.
    assign per_stb   = (state_q == StStrobe);
    assign per_wen   = per_stb & wen_q;
    assign per_addr  = addr_q;
    assign per_wdata = wdata_q;
    assign per_be    = be_q;

    always_comb begin
        per_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            per_sel[i] = per_stb && (slot_q == SLOT_W'(i));
        end
    end

    // CPU and cache outputs. Outside IDLE an access is always a peripheral one,
    // whatever the CPU address currently shows.
    always_comb begin
        dc_read_out   = 1'b0;
        dc_write_out  = 1'b0;
        mem_stall     = 1'b0;
        dmem_data_out = '0;
        if (state_q == StIdle && !per_start) begin
            dc_read_out   = dmem_read_in;
            dc_write_out  = dmem_write_in;
            mem_stall     = cache_stall;
            dmem_data_out = dc_data_in;
        end else begin
            mem_stall = (state_q != StDone);
            if (state_q == StDone && !wen_q) begin
                dmem_data_out = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Directed self-checking bench for mmio_router with the default slot map:
// slot0 id c wait 2, slot1 id d wait 0, slot2 id e wait 0, slot3 id f wait 1.
module tb_mmio_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, wr;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic [31:0]  dmem_data_out;
    logic         mem_stall;
    logic         dc_read_out, dc_write_out;
    logic [31:0]  dc_data_in;
    logic         cache_stall;
    logic [3:0]   per_sel;
    logic         per_stb, per_wen;
    logic [29:0]  per_addr;
    logic [31:0]  per_wdata;
    logic [3:0]   per_be;
    logic [127:0] per_rdata;

    int n_tests;
    int n_fail;

    // Values seen on the strobe cycle of the latest access.
    logic [3:0]   stb_sel;
    logic         stb_wen;
    logic [29:0]  stb_addr;
    logic [31:0]  stb_wdata;
    logic [3:0]   stb_be;

    int stalls, strobes, stalls2, strobes2;

    always #5 clk = ~clk;

    mmio_router dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_read_in   (rd),
        .dmem_write_in  (wr),
        .dmem_addr      (addr),
        .data_from_reg  (wdata),
        .dmem_byte_w_en (be),
        .dmem_data_out  (dmem_data_out),
        .mem_stall      (mem_stall),
        .dc_read_out    (dc_read_out),
        .dc_write_out   (dc_write_out),
        .dc_data_in     (dc_data_in),
        .cache_stall    (cache_stall),
        .per_sel        (per_sel),
        .per_stb        (per_stb),
        .per_wen        (per_wen),
        .per_addr       (per_addr),
        .per_wdata      (per_wdata),
        .per_be         (per_be),
        .per_rdata      (per_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until mem_stall drops (DONE cycle), counting stall cycles and strobes.
    // Drives rval onto the slot's per_rdata slice in the cycle after the strobe.
    task automatic run_access(input int slot, input logic [31:0] rval,
                              output int n_stall, output int n_stb);
        int guard;
        bit stb_prev;
        n_stall  = 0;
        n_stb    = 0;
        guard    = 0;
        #1;
        while (mem_stall && guard < 20) begin
            n_stall++;
            stb_prev = per_stb;
            if (per_stb) begin
                n_stb++;
                stb_sel   = per_sel;
                stb_wen   = per_wen;
                stb_addr  = per_addr;
                stb_wdata = per_wdata;
                stb_be    = per_be;
            end
            step();
            if (stb_prev) per_rdata[slot*32 +: 32] = rval;
            #1;
            guard++;
        end
        check("access_bound", guard < 20, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        stb_sel = '0; stb_wen = 1'b0; stb_addr = '0; stb_wdata = '0; stb_be = '0;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        dc_data_in = 32'h1234_5678; cache_stall = 1'b0; per_rdata = '0;

        // Reset state
        #2;
        check("rst_stb",   per_stb,   1'b0);
        check("rst_sel",   per_sel,   4'b0000);
        check("rst_wen",   per_wen,   1'b0);
        check("rst_addr",  per_addr,  30'h0);
        check("rst_wdata", per_wdata, 32'h0);
        check("rst_be",    per_be,    4'h0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_dout",  dmem_data_out, 32'h1234_5678);
        rd = 1'b1; addr = 30'h3000_0000;
        #1;
        check("rst_per_stall", mem_stall,   1'b1);
        check("rst_per_dcrd",  dc_read_out, 1'b0);
        check("rst_per_dout",  dmem_data_out, 32'h0);
        rd = 1'b0; addr = '0;
        step();
        rst = 1'b1;
        step();

        // Cache pass-through load, cache stalls for 3 cycles
        rd = 1'b1; addr = 30'h0000_0100; cache_stall = 1'b1; dc_data_in = 32'hCAFE_0001;
        #1;
        check("c_dcrd",  dc_read_out,  1'b1);
        check("c_dcwr",  dc_write_out, 1'b0);
        check("c_stall", mem_stall,    1'b1);
        check("c_dout",  dmem_data_out, 32'hCAFE_0001);
        check("c_stb",   per_stb,      1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("c_stall_hold", mem_stall, 1'b1);
            check("c_stb_hold",   per_stb,   1'b0);
        end
        step();
        cache_stall = 1'b0; dc_data_in = 32'hCAFE_0002;
        #1;
        check("c_stall_end", mem_stall, 1'b0);
        check("c_dout_end",  dmem_data_out, 32'hCAFE_0002);
        check("c_stb_end",   per_stb, 1'b0);
        step();
        rd = 1'b0;

        // Slot 0 store, W=2
        wr = 1'b1; addr = 30'h3000_0004; wdata = 32'h0000_0041; be = 4'b1000;
        run_access(0, 32'h0, stalls, strobes);
        check("s0_stalls",  stalls,    4);
        check("s0_strobes", strobes,   1);
        check("s0_wen",     stb_wen,   1'b1);
        check("s0_sel",     stb_sel,   4'b0001);
        check("s0_addr",    stb_addr,  30'h3000_0004);
        check("s0_wdata",   stb_wdata, 32'h0000_0041);
        check("s0_be",      stb_be,    4'b1000);
        check("s0_dout",    dmem_data_out, 32'h0);
        check("s0_dcwr",    dc_write_out, 1'b0);
        step();
        wr = 1'b0;

        // Slot 3 read, W=1, data appears one cycle after the strobe
        rd = 1'b1; addr = 30'h3C00_0010;
        run_access(3, 32'hDEAD_BEEF, stalls, strobes);
        check("s3_stalls",  stalls,  3);
        check("s3_strobes", strobes, 1);
        check("s3_sel",     stb_sel, 4'b1000);
        check("s3_wen",     stb_wen, 1'b0);
        check("s3_dout",    dmem_data_out, 32'hDEAD_BEEF);
        check("s3_dcrd",    dc_read_out, 1'b0);
        step();
        rd = 1'b0;

        // Back-to-back stores to the same slot 2 address, W=0
        wr = 1'b1; addr = 30'h3800_0020; wdata = 32'h1111_2222; be = 4'hF;
        run_access(2, 32'h0, stalls, strobes);
        check("b2b_stalls1",  stalls,  2);
        check("b2b_strobes1", strobes, 1);
        check("b2b_sel",      stb_sel, 4'b0100);
        step();
        check("b2b_gap_stb",   per_stb,   1'b0);
        check("b2b_gap_stall", mem_stall, 1'b1);
        run_access(2, 32'h0, stalls2, strobes2);
        check("b2b_stalls2",  stalls2,  2);
        check("b2b_strobes2", strobes2, 1);
        step();
        wr = 1'b0;

        // Read and write together to slot 1: handled as a write
        per_rdata[63:32] = 32'h5555_AAAA;
        rd = 1'b1; wr = 1'b1; addr = 30'h3400_0008; wdata = 32'h0000_00AB; be = 4'b0011;
        run_access(1, 32'h5555_AAAA, stalls, strobes);
        check("rw_stalls", stalls,  2);
        check("rw_wen",    stb_wen, 1'b1);
        check("rw_sel",    stb_sel, 4'b0010);
        check("rw_be",     stb_be,  4'b0011);
        check("rw_dout",   dmem_data_out, 32'h0);
        step();
        rd = 1'b0; wr = 1'b0;

        // Slot 0 read with CPU address changed during WAIT
        per_rdata[31:0] = 32'h0BAD_F00D;
        rd = 1'b1; addr = 30'h3000_0010;
        #1;
        check("chg_stall0", mem_stall, 1'b1);
        step();
        check("chg_stb", per_stb, 1'b1);
        step();
        addr = 30'h0000_0200; wdata = 32'hFFFF_FFFF;
        #1;
        check("chg_dcrd",   dc_read_out, 1'b0);
        check("chg_stall1", mem_stall, 1'b1);
        check("chg_addr1",  per_addr, 30'h3000_0010);
        step();
        check("chg_addr2",  per_addr, 30'h3000_0010);
        check("chg_stall2", mem_stall, 1'b1);
        step();
        check("chg_done",   mem_stall, 1'b0);
        check("chg_dout",   dmem_data_out, 32'h0BAD_F00D);
        check("chg_addr3",  per_addr, 30'h3000_0010);
        step();
        rd = 1'b0; addr = '0;

        // Reset during WAIT, request held through reset
        wr = 1'b1; addr = 30'h3000_0008; wdata = 32'h0000_0077; be = 4'hF;
        step();
        step();
        rst = 1'b0;
        #1;
        check("ra_stb",   per_stb,   1'b0);
        check("ra_sel",   per_sel,   4'b0000);
        check("ra_wen",   per_wen,   1'b0);
        check("ra_addr",  per_addr,  30'h0);
        check("ra_wdata", per_wdata, 32'h0);
        check("ra_be",    per_be,    4'h0);
        check("ra_stall", mem_stall, 1'b1);
        step();
        check("ra_stb_hold", per_stb, 1'b0);
        rst = 1'b1;
        run_access(0, 32'h0, stalls, strobes);
        check("ra_stalls",  stalls,    4);
        check("ra_strobes", strobes,   1);
        check("ra_new_addr", stb_addr, 30'h3000_0008);
        check("ra_new_data", stb_wdata, 32'h0000_0077);
        step();
        wr = 1'b0;
        #1;
        check("ra_idle_stall", mem_stall, 1'b0);
        check("ra_idle_stb",   per_stb,   1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
